// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: turns MIPS byte/half/word accesses into aligned word-bus
// transactions, with read-modify-write for sub-word stores and big-endian lane mapping.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        addr_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE, ERR} state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        req_valid;
    logic        req_err;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Classify the incoming request; byte ops can never be misaligned.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = addr[0];
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |addr[1:0];
            end
            OP_SB: is_store = 1'b1;
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = addr[0];
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |addr[1:0];
            end
            default: ;
        endcase
        req_valid = mem_read | mem_write;
        req_err   = (mem_read & mem_write) | (mem_read & ~is_load) |
                    (mem_write & ~is_store) | misaligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        addr_err   = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_valid) begin
                    if (req_err) begin
                        next_state = ERR;
                    end else if (mem_read) begin
                        next_state = RD;
                    end else if (op == OP_SW) begin
                        next_state = WR;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            RD: begin
                bus_req = 1'b1;
                if (bus_ack) next_state = DONE;
            end
            RMW_RD: begin
                bus_req = 1'b1;
                if (bus_ack) next_state = WR;
            end
            WR: begin
                bus_req = 1'b1;
                bus_we  = 1'b1;
                if (bus_ack) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                addr_err   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        case (off_q)
            2'd0:    sel_byte = bus_rdata[31:24];
            2'd1:    sel_byte = bus_rdata[23:16];
            2'd2:    sel_byte = bus_rdata[15:8];
            default: sel_byte = bus_rdata[7:0];
        endcase
        sel_half = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];

        case (op_q)
            OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_ext = {24'd0, sel_byte};
            OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_ext = {16'd0, sel_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        merged = bus_rdata;
        if (op_q == OP_SB) begin
            case (off_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (op_q == OP_SH) begin
            if (off_q[1]) begin
                merged[15:0] = wdata_q;
            end else begin
                merged[31:16] = wdata_q;
            end
        end
    end

    // Request fields are captured once at acceptance so later input changes cannot disturb the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 6'd0;
            off_q     <= 2'd0;
            wdata_q   <= 16'd0;
            rdata     <= 32'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !req_err) begin
                        op_q      <= op;
                        off_q     <= addr[1:0];
                        wdata_q   <= wdata[15:0];
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= wdata;
                    end
                end
                RD: begin
                    if (bus_ack) rdata <= load_ext;
                end
                RMW_RD: begin
                    if (bus_ack) bus_wdata <= merged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning), clock and reset first:
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 mem_read  in  1  load request from the multicycle controller.
REQ-005 mem_write  in  1  store request from the multicycle controller.
REQ-006 op  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
REQ-007 addr  in  32  byte address (ALU result).
REQ-008 wdata  in  32  store data (rt value).
REQ-009 rdata  out  32  extended load result (memory data register).
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high whenever FSM is not IDLE.
REQ-012 addr_err  out  1  one-cycle pulse on misaligned, unknown-op or conflicting request.
REQ-013 bus_req  out  1  word-bus request.
REQ-014 bus_we  out  1  word-bus write enable.
REQ-015 bus_addr  out  32  word address; bits 1:0 always 00.
REQ-016 bus_wdata  out  32  word write data.
REQ-017 bus_rdata  in  32  word read data, valid when bus_ack=1.
REQ-018 bus_ack  in  1  bus completion; any latency >=0 cycles after bus_req rises.

Function
REQ-019 FSM states SHALL be IDLE, RD, RMW_RD, WR, DONE, ERR.
REQ-020 In IDLE a request SHALL be accepted on the edge where mem_read or mem_write is 1; addr, op, wdata latched; later input changes ignored.
REQ-021 Requests while not in IDLE (including DONE, ERR) SHALL be ignored, not queued.
REQ-022 mem_read=1 and mem_write=1 together, mem_read with a store op, mem_write with a load op, or any other op -> ERR.
REQ-023 Misalignment -> ERR: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; byte ops never misaligned.
REQ-024 ERR: addr_err=1 and done=1 for exactly one cycle, no bus access, rdata unchanged, then IDLE.
REQ-025 Accepted load -> RD; SW -> WR with bus_wdata=wdata; SB/SH -> RMW_RD.
REQ-026 In RD/RMW_RD: bus_req=1, bus_we=0, bus_addr={addr[31:2],00}; held stable until edge sampling bus_ack=1.
REQ-027 RD on ack: rdata updated from bus_rdata, next state DONE.
REQ-028 RMW_RD on ack: merged word captured into bus_wdata, next state WR.
REQ-029 In WR: bus_req=1, bus_we=1, bus_addr and bus_wdata stable until ack; on ack -> DONE.
REQ-030 Byte lanes SHALL be big-endian: offset 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0; halfword offset 0 -> 31:16, 2 -> 15:0.
REQ-031 LB/LH sign-extend, LBU/LHU zero-extend the selected lane to 32 bits; LW passes word unchanged.
REQ-032 SB/SH replace only the selected lane with wdata[7:0] / wdata[15:0]; other lanes keep read data.
REQ-033 DONE: done=1 for one cycle, bus_req=0, then IDLE.
REQ-034 bus_req SHALL be 0 in IDLE, DONE, ERR; bus_we=0 outside WR.
REQ-035 busy SHALL be 1 in RD, RMW_RD, WR, DONE, ERR; 0 in IDLE.
REQ-036 Latency with zero-wait ack: load/SW done 2 cycles after acceptance edge; SB/SH done 3 cycles after; each wait cycle adds one.
REQ-037 bus_ack while bus_req=0 SHALL be ignored.

Reset
REQ-038 rst=1 SHALL immediately force IDLE and rdata=0, done=0, busy=0, addr_err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
REQ-039 Reset mid-transaction SHALL abort it (bus_req drops without waiting for ack); no completion pulse follows.

Verification
REQ-040 LB addr=0x103, bus_rdata=0x1122_33F0, ack immediate -> bus_addr=0x100, rdata=0xFFFF_FFF0, done 2 cycles after accept.
REQ-041 LHU addr=0x202, bus_rdata=0xAAAA_8001 -> rdata=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-042 SB addr=0x301, wdata=0x55, memory 0x1122_3344, ack delayed 3 cycles each phase -> written 0x1155_3344, bus signals stable during wait, done once.
REQ-043 LW addr=0x402, or SH addr=0x1, or mem_read=mem_write=1 -> addr_err=1 and done=1 one cycle, bus_req never 1.
REQ-044 rst asserted during WR wait -> bus_req=0 same cycle, all outputs reset values, no done; next SW after release completes normally.
REQ-045 New mem_read pulsed during DONE -> ignored, bus_req stays 0.
